// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, issues single-beat imem requests,
// buffers fetched words in a 2-entry prefetch queue and applies branch redirects.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          DEPTH        = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        thumb,
  input  logic        branch_taken,
  input  logic [31:0] new_PC,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic [31:0] current_PC,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   target_q, target_nxt;
  logic [31:0]   br_target;
  logic [31:0]   pc_step;
  logic [CW-1:0] count;
  logic [31:0]   q_word [2];
  logic [31:0]   q_pc   [2];
  logic          push;
  logic          pop;

  // Handshake: a request is outstanding from the first cycle imem_req=1 until the
  // cycle imem_ack=1; imem_req and imem_addr hold steady throughout. imem_ack while
  // imem_req=0 is ignored. Because count only grows on an ack, imem_req in REQ
  // cannot drop while a request is outstanding.
  assign br_target = thumb ? {new_PC[31:1], 1'b0} : {new_PC[31:2], 2'b00};
  assign pc_step   = thumb ? 32'd2 : 32'd4;
  assign imem_addr = fetch_pc;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    target_nxt   = target_q;
    imem_req     = 1'b0;
    push         = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = REQ;
      end
      REQ: begin
        imem_req = (count < CW'(DEPTH));
        if (branch_taken) begin
          if (imem_req && !imem_ack) begin
            target_nxt = br_target;
            state_nxt  = DRAIN;
          end else begin
            fetch_pc_nxt = br_target;
          end
        end else if (imem_req && imem_ack) begin
          push         = 1'b1;
          fetch_pc_nxt = fetch_pc + pc_step;
        end
      end
      DRAIN: begin
        // Stale request must complete at its old address; its data is dropped.
        imem_req = 1'b1;
        if (imem_ack) begin
          fetch_pc_nxt = branch_taken ? br_target : target_q;
          state_nxt    = REQ;
        end else if (branch_taken) begin
          target_nxt = br_target;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_VECTOR;
      target_q <= RESET_VECTOR;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      target_q <= target_nxt;
    end
  end

  assign instr_valid = (count != '0);
  assign pop         = instr_valid && !stall && !branch_taken;

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      q_word[0] <= '0;
      q_word[1] <= '0;
      q_pc[0]   <= '0;
      q_pc[1]   <= '0;
    end else if (branch_taken) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          q_word[count[0]] <= imem_rdata;
          q_pc[count[0]]   <= fetch_pc;
          count            <= count + CW'(1);
        end
        2'b01: begin
          q_word[0] <= q_word[1];
          q_pc[0]   <= q_pc[1];
          count     <= count - CW'(1);
        end
        2'b11: begin
          if (count == CW'(1)) begin
            q_word[0] <= imem_rdata;
            q_pc[0]   <= fetch_pc;
          end else begin
            q_word[0] <= q_word[1];
            q_pc[0]   <= q_pc[1];
            q_word[1] <= imem_rdata;
            q_pc[1]   <= fetch_pc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign instruction = q_word[0];
  assign instr_pc    = q_pc[0];
  assign current_PC  = instr_pc + (thumb ? 32'd4 : 32'd8);
  assign dbg_state   = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: linear cycle-by-cycle stimulus with
// hand-computed expectations checked by immediate assertions.
module tb_fetch_sequencer;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic        clk;
  logic        rst_n;
  logic        thumb;
  logic        branch_taken;
  logic [31:0] new_PC;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [31:0] current_PC;
  logic [1:0]  dbg_state;

  int n_vec;
  int n_err;

  fetch_sequencer #(.RESET_VECTOR(32'h0000_0000), .DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .thumb        (thumb),
    .branch_taken (branch_taken),
    .new_PC       (new_PC),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instruction  (instruction),
    .instr_pc     (instr_pc),
    .current_PC   (current_PC),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content: every word is a fixed function of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hE000_0000;
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    thumb = 1'b0;
    branch_taken = 1'b0;
    new_PC = '0;
    stall = 1'b0;
    imem_ack = 1'b0;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_pc",    instr_pc, 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));

    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_state", 32'(dbg_state), 32'(S_IDLE));
    chk("idle_req",   32'(imem_req), 32'd0);

    // Streaming fetch with ack every requested cycle
    tick(); imem_ack = 1'b1;
    @(negedge clk);
    chk("c1_req",   32'(imem_req), 32'd1);
    chk("c1_addr",  imem_addr, 32'h0);
    chk("c1_valid", 32'(instr_valid), 32'd0);

    tick();
    @(negedge clk);
    chk("c2_addr",  imem_addr, 32'h4);
    chk("c2_valid", 32'(instr_valid), 32'd1);
    chk("c2_ipc",   instr_pc, 32'h0);
    chk("c2_instr", instruction, mem_word(32'h0));
    chk("c2_cpc",   current_PC, 32'h8);

    // Stall fills the queue, then request resumes after a pop
    tick(); stall = 1'b1;
    @(negedge clk);
    chk("c3_addr", imem_addr, 32'h8);
    chk("c3_ipc",  instr_pc, 32'h4);

    tick();
    @(negedge clk);
    chk("c4_full_req", 32'(imem_req), 32'd0);
    chk("c4_ipc",      instr_pc, 32'h4);
    chk("c4_valid",    32'(instr_valid), 32'd1);

    tick(); stall = 1'b0;
    @(negedge clk);
    chk("c5_full_req", 32'(imem_req), 32'd0);
    chk("c5_ipc",      instr_pc, 32'h4);

    tick(); imem_ack = 1'b0;
    @(negedge clk);
    chk("c6_req",   32'(imem_req), 32'd1);
    chk("c6_addr",  imem_addr, 32'hC);
    chk("c6_ipc",   instr_pc, 32'h8);
    chk("c6_instr", instruction, mem_word(32'h8));

    // Redirect with request outstanding and ack delayed
    tick(); branch_taken = 1'b1; new_PC = 32'h0000_0103;
    @(negedge clk);
    chk("c7_valid", 32'(instr_valid), 32'd0);
    chk("c7_addr",  imem_addr, 32'hC);

    tick(); branch_taken = 1'b0;
    @(negedge clk);
    chk("c8_state", 32'(dbg_state), 32'(S_DRAIN));
    chk("c8_req",   32'(imem_req), 32'd1);
    chk("c8_addr",  imem_addr, 32'hC);
    chk("c8_valid", 32'(instr_valid), 32'd0);

    tick();
    @(negedge clk);
    chk("c9_addr",  imem_addr, 32'hC);

    tick(); imem_ack = 1'b1;
    @(negedge clk);
    chk("c10_state", 32'(dbg_state), 32'(S_DRAIN));
    chk("c10_addr",  imem_addr, 32'hC);

    tick();
    @(negedge clk);
    chk("c11_state", 32'(dbg_state), 32'(S_REQ));
    chk("c11_addr",  imem_addr, 32'h100);
    chk("c11_valid", 32'(instr_valid), 32'd0);

    // Redirect in the same cycle as an ack and a pop
    tick(); branch_taken = 1'b1; new_PC = 32'h0000_0300;
    @(negedge clk);
    chk("c12_valid", 32'(instr_valid), 32'd1);
    chk("c12_ipc",   instr_pc, 32'h100);
    chk("c12_instr", instruction, mem_word(32'h100));
    chk("c12_addr",  imem_addr, 32'h104);

    tick(); branch_taken = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    chk("c13_valid", 32'(instr_valid), 32'd0);
    chk("c13_addr",  imem_addr, 32'h300);
    chk("c13_state", 32'(dbg_state), 32'(S_REQ));

    // Thumb redirect into DRAIN, then overwrite of the latched target
    tick(); branch_taken = 1'b1; new_PC = 32'h0000_0555; thumb = 1'b1;
    @(negedge clk);
    chk("c14_valid", 32'(instr_valid), 32'd0);
    chk("c14_addr",  imem_addr, 32'h300);

    tick(); new_PC = 32'h0000_0201;
    @(negedge clk);
    chk("c15_state", 32'(dbg_state), 32'(S_DRAIN));
    chk("c15_addr",  imem_addr, 32'h300);

    tick(); branch_taken = 1'b0; imem_ack = 1'b1;
    @(negedge clk);
    chk("c16_state", 32'(dbg_state), 32'(S_DRAIN));
    chk("c16_addr",  imem_addr, 32'h300);

    tick();
    @(negedge clk);
    chk("c17_state", 32'(dbg_state), 32'(S_REQ));
    chk("c17_addr",  imem_addr, 32'h200);
    chk("c17_valid", 32'(instr_valid), 32'd0);

    tick();
    @(negedge clk);
    chk("c18_addr",  imem_addr, 32'h202);
    chk("c18_ipc",   instr_pc, 32'h200);
    chk("c18_cpc",   current_PC, 32'h204);
    chk("c18_instr", instruction, mem_word(32'h200));

    tick();
    @(negedge clk);
    chk("c19_addr", imem_addr, 32'h204);
    chk("c19_ipc",  instr_pc, 32'h202);
    chk("c19_cpc",  current_PC, 32'h206);
    // Back to ARM with a redirect near the top of memory, acked the same cycle
    thumb = 1'b0; branch_taken = 1'b1; new_PC = 32'hFFFF_FFFF;

    tick(); branch_taken = 1'b0;
    @(negedge clk);
    chk("c20_valid", 32'(instr_valid), 32'd0);
    chk("c20_addr",  imem_addr, 32'hFFFF_FFFC);

    tick();
    @(negedge clk);
    chk("c21_wrap_addr", imem_addr, 32'h0);
    chk("c21_ipc",       instr_pc, 32'hFFFF_FFFC);
    chk("c21_cpc_wrap",  current_PC, 32'h4);
    imem_ack = 1'b0;

    tick();
    @(negedge clk);
    chk("c22_valid", 32'(instr_valid), 32'd0);
    chk("c22_req",   32'(imem_req), 32'd1);
    branch_taken = 1'b1; new_PC = 32'h0000_0400;

    // Async reset in the middle of DRAIN
    tick(); branch_taken = 1'b0;
    @(negedge clk);
    chk("c23_state", 32'(dbg_state), 32'(S_DRAIN));
    chk("c23_req",   32'(imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst2_req",   32'(imem_req), 32'd0);
    chk("rst2_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst2_addr",  imem_addr, 32'h0);
    chk("rst2_valid", 32'(instr_valid), 32'd0);

    tick(); rst_n = 1'b1; imem_ack = 1'b1;
    @(negedge clk);
    chk("r24_state", 32'(dbg_state), 32'(S_IDLE));
    chk("r24_req",   32'(imem_req), 32'd0);

    tick();
    @(negedge clk);
    chk("r25_addr", imem_addr, 32'h0);
    chk("r25_req",  32'(imem_req), 32'd1);

    tick();
    @(negedge clk);
    chk("r26_valid", 32'(instr_valid), 32'd1);
    chk("r26_ipc",   instr_pc, 32'h0);
    chk("r26_addr",  imem_addr, 32'h4);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
